// File: rtl/gene_net_sim.sv
// Programmable synchronous Boolean gene-network simulator: steps a seed state through
// mask-defined rules until it reaches a fixed point, an attractor cycle, or a step limit.
module gene_net_sim #(
  parameter int N    = 8,
  parameter int HIST = 8,
  parameter int CW   = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cfg_we,
  input  logic [$clog2(N)-1:0]       cfg_gene,
  input  logic [1:0]                 cfg_sel,
  input  logic [N-1:0]               cfg_mask,
  input  logic                       start,
  input  logic [N-1:0]               seed,
  input  logic [CW-1:0]              max_steps,
  output logic                       busy,
  output logic                       done,
  output logic [1:0]                 status,
  output logic [$clog2(HIST+1)-1:0]  period,
  output logic [CW-1:0]              step_cnt,
  output logic [N-1:0]               x_out
);
  localparam int GW = $clog2(N);
  localparam int PW = $clog2(HIST+1);
  // Keep at least one history slot so HIST=1 still elaborates; its valid bit never sets.
  localparam int HL = (HIST > 1) ? HIST - 1 : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nxt;

  logic [N-1:0]  any_m [N];
  logic [N-1:0]  all_m [N];
  logic [N-1:0]  rep_m [N];
  logic [N-1:0]  hist  [HL];
  logic [HL-1:0] hist_vld;

  logic [N-1:0]  nxt;
  logic          match;
  logic [PW-1:0] match_p;
  logic          timeout;
  logic [GW:0]   gene_ext;
  logic          cfg_ok;
  logic          launch;

  function automatic logic rule_eval(input logic [N-1:0] s, input logic [N-1:0] a,
                                     input logic [N-1:0] l, input logic [N-1:0] r);
    return ((a == '0) || (|(s & a))) && ((s & l) == l) && !(|(s & r));
  endfunction

  always_comb begin
    nxt = '0;
    for (int i = 0; i < N; i++)
      nxt[i] = rule_eval(x_out, any_m[i], all_m[i], rep_m[i]);
  end

  // Scan longest period first so the shortest matching period overrides it.
  always_comb begin
    match   = 1'b0;
    match_p = '0;
    for (int k = HIST - 2; k >= 0; k--) begin
      if (hist_vld[k] && (hist[k] == nxt)) begin
        match   = 1'b1;
        match_p = PW'(k + 2);
      end
    end
    if (nxt == x_out) begin
      match   = 1'b1;
      match_p = PW'(1);
    end
  end

  assign timeout  = (max_steps != '0) && ((step_cnt + CW'(1)) == max_steps);
  assign gene_ext = {1'b0, cfg_gene};
  assign cfg_ok   = cfg_we && (state != RUN) && (gene_ext < (GW+1)'(N)) && (cfg_sel != 2'd3);
  assign launch   = start && (state != RUN);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start) state_nxt = RUN;
      RUN:        if (match || timeout) state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        any_m[i] <= '0;
        all_m[i] <= '0;
        rep_m[i] <= '0;
      end
      for (int k = 0; k < HL; k++) hist[k] <= '0;
      hist_vld <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      status   <= 2'd0;
      period   <= '0;
      step_cnt <= '0;
      x_out    <= '0;
    end else begin
      if (cfg_ok) begin
        case (cfg_sel)
          2'd0:    any_m[cfg_gene] <= cfg_mask;
          2'd1:    all_m[cfg_gene] <= cfg_mask;
          2'd2:    rep_m[cfg_gene] <= cfg_mask;
          default: ;
        endcase
      end
      if (launch) begin
        x_out    <= seed;
        step_cnt <= '0;
        hist_vld <= '0;
        done     <= 1'b0;
        status   <= 2'd0;
        period   <= '0;
        busy     <= 1'b1;
      end else if (state == RUN) begin
        // One network step: advance state, age history, saturate the step count.
        x_out <= nxt;
        if (step_cnt != '1) step_cnt <= step_cnt + CW'(1);
        hist[0]     <= x_out;
        hist_vld[0] <= (HIST > 1);
        for (int k = 1; k < HL; k++) begin
          hist[k]     <= hist[k-1];
          hist_vld[k] <= hist_vld[k-1];
        end
        if (match) begin
          busy   <= 1'b0;
          done   <= 1'b1;
          period <= match_p;
          status <= (match_p == PW'(1)) ? 2'd1 : 2'd2;
        end else if (timeout) begin
          busy   <= 1'b0;
          done   <= 1'b1;
          period <= '0;
          status <= 2'd3;
        end
      end
    end
  end

endmodule

// File: tb/tb_gene_net_sim.sv
// Scoreboard bench for gene_net_sim: a default build and a HIST=1 build share config and reset.
module tb_gene_net_sim;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_we = 1'b0;
  logic [2:0]  cfg_gene = '0;
  logic [1:0]  cfg_sel = '0;
  logic [7:0]  cfg_mask = '0;
  logic        start = 1'b0;
  logic        start_h1 = 1'b0;
  logic [7:0]  seed = '0;
  logic [15:0] max_steps = '0;
  logic [15:0] max_steps_h1 = '0;

  logic        busy, done;
  logic [1:0]  status;
  logic [3:0]  period;
  logic [15:0] step_cnt;
  logic [7:0]  x_out;
  logic        busy_h1, done_h1;
  logic [1:0]  status_h1;
  logic [0:0]  period_h1;
  logic [15:0] step_cnt_h1;
  logic [7:0]  x_out_h1;

  int total = 0;
  int bad = 0;

  typedef struct packed {
    logic [1:0]  st;
    logic [3:0]  per;
    logic [15:0] cnt;
    logic [7:0]  x;
  } res_t;

  res_t       exp_q[$];
  logic [7:0] traj_q[$];

  gene_net_sim #(.N(8), .HIST(8), .CW(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_gene(cfg_gene), .cfg_sel(cfg_sel),
    .cfg_mask(cfg_mask), .start(start), .seed(seed), .max_steps(max_steps),
    .busy(busy), .done(done), .status(status), .period(period), .step_cnt(step_cnt),
    .x_out(x_out)
  );

  gene_net_sim #(.N(8), .HIST(1), .CW(16)) u_h1 (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_gene(cfg_gene), .cfg_sel(cfg_sel),
    .cfg_mask(cfg_mask), .start(start_h1), .seed(seed), .max_steps(max_steps_h1),
    .busy(busy_h1), .done(done_h1), .status(status_h1), .period(period_h1),
    .step_cnt(step_cnt_h1), .x_out(x_out_h1)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input int g, input int sel, input logic [7:0] m);
    cfg_we   = 1'b1;
    cfg_gene = 3'(g);
    cfg_sel  = 2'(sel);
    cfg_mask = m;
    tick();
    cfg_we   = 1'b0;
  endtask

  task automatic load_rules();
    logic [7:0] any_t [8];
    logic [7:0] all_t [8];
    logic [7:0] rep_t [8];
    any_t = '{8'h00, 8'h30, 8'h00, 8'h00, 8'h0A, 8'h00, 8'h00, 8'h48};
    all_t = '{8'h40, 8'h00, 8'h80, 8'h02, 8'h00, 8'h04, 8'h02, 8'h00};
    rep_t = '{8'h84, 8'h80, 8'h00, 8'h40, 8'h00, 8'h80, 8'h80, 8'h03};
    for (int g = 0; g < 8; g++) begin
      cfg_write(g, 0, any_t[g]);
      cfg_write(g, 1, all_t[g]);
      cfg_write(g, 2, rep_t[g]);
    end
  endtask

  task automatic launch(input logic [7:0] s, input logic [15:0] ms);
    seed      = s;
    max_steps = ms;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    res_t got;
    rst_n = 1'b0;
    tick();
    tick();
    got = {status, period, step_cnt, x_out};
    total++;
    if (got !== res_t'(0)) begin
      bad++;
      $display("FAIL reset_outputs got=%h want=%h", got, res_t'(0));
    end
    total++;
    if ({busy, done} !== 2'b00) begin
      bad++;
      $display("FAIL reset_flags busy/done got=%b want=00", {busy, done});
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_fixed_point();
    bit   ok;
    res_t got, e;
    exp_q.push_back({2'd1, 4'd1, 16'd1, 8'h00});
    launch(8'h00, 16'd0);
    wait_done(ok);
    e = exp_q.pop_front();
    got = {status, period, step_cnt, x_out};
    total++;
    if (!ok || got !== e) begin
      bad++;
      $display("FAIL fixed_point done=%b got=%h want=%h", done, got, e);
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL fixed_point_busy got=%b want=0", busy);
    end
    // Match and timeout on the same step: the match must win.
    exp_q.push_back({2'd1, 4'd1, 16'd1, 8'h00});
    launch(8'h00, 16'd1);
    wait_done(ok);
    e = exp_q.pop_front();
    got = {status, period, step_cnt, x_out};
    total++;
    if (!ok || got !== e) begin
      bad++;
      $display("FAIL match_beats_timeout done=%b got=%h want=%h", done, got, e);
    end
  endtask

  task automatic test_cycle();
    res_t       got, e;
    logic [7:0] ex;
    bit         seen = 1'b0;
    traj_q = '{8'h58, 8'h93, 8'h1C, 8'hB2, 8'h1C};
    exp_q.push_back({2'd2, 4'd2, 16'd5, 8'h1C});
    launch(8'h02, 16'd0);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (traj_q.size() > 0) begin
        ex = traj_q.pop_front();
        total++;
        if (x_out !== ex) begin
          bad++;
          $display("FAIL trajectory step=%0d got=%h want=%h", i + 1, x_out, ex);
        end
      end
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    e = exp_q.pop_front();
    got = {status, period, step_cnt, x_out};
    total++;
    if (!seen || got !== e) begin
      bad++;
      $display("FAIL cycle_result done=%b got=%h want=%h", done, got, e);
    end
  endtask

  task automatic test_timeout();
    bit   ok;
    res_t got, e;
    exp_q.push_back({2'd3, 4'd0, 16'd3, 8'h1C});
    launch(8'h02, 16'd3);
    wait_done(ok);
    e = exp_q.pop_front();
    got = {status, period, step_cnt, x_out};
    total++;
    if (!ok || got !== e) begin
      bad++;
      $display("FAIL timeout done=%b got=%h want=%h", done, got, e);
    end
  endtask

  task automatic test_hist1();
    bit   ok = 1'b0;
    res_t got, e;
    exp_q.push_back({2'd3, 4'd0, 16'd20, 8'hB2});
    seed         = 8'h02;
    max_steps_h1 = 16'd20;
    start_h1     = 1'b1;
    tick();
    start_h1     = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (done_h1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    e = exp_q.pop_front();
    got = {status_h1, 3'b000, period_h1, step_cnt_h1, x_out_h1};
    total++;
    if (!ok || got !== e) begin
      bad++;
      $display("FAIL hist1_no_cycle done=%b got=%h want=%h", done_h1, got, e);
    end
  endtask

  task automatic test_ignored();
    bit   ok;
    res_t got, e;
    // A select-3 write must not touch any mask.
    cfg_write(4, 3, 8'hFF);
    exp_q.push_back({2'd2, 4'd2, 16'd5, 8'h1C});
    launch(8'h02, 16'd0);
    tick();
    cfg_we   = 1'b1;
    cfg_gene = 3'd4;
    cfg_sel  = 2'd2;
    cfg_mask = 8'hFF;
    tick();
    cfg_we   = 1'b0;
    seed     = 8'h00;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    wait_done(ok);
    e = exp_q.pop_front();
    got = {status, period, step_cnt, x_out};
    total++;
    if (!ok || got !== e) begin
      bad++;
      $display("FAIL run_perturbed done=%b got=%h want=%h", done, got, e);
    end
    exp_q.push_back({2'd2, 4'd2, 16'd5, 8'h1C});
    launch(8'h02, 16'd0);
    wait_done(ok);
    e = exp_q.pop_front();
    got = {status, period, step_cnt, x_out};
    total++;
    if (!ok || got !== e) begin
      bad++;
      $display("FAIL rules_intact done=%b got=%h want=%h", done, got, e);
    end
  endtask

  task automatic test_mid_reset();
    bit   ok;
    res_t got, e;
    launch(8'h02, 16'd0);
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    got = {status, period, step_cnt, x_out};
    total++;
    if (got !== res_t'(0) || {busy, done} !== 2'b00) begin
      bad++;
      $display("FAIL mid_reset busy=%b done=%b got=%h want=%h", busy, done, got, res_t'(0));
    end
    rst_n = 1'b1;
    tick();
    exp_q.push_back({2'd1, 4'd1, 16'd2, 8'hFF});
    launch(8'h00, 16'd0);
    tick();
    total++;
    if ({x_out, step_cnt} !== {8'hFF, 16'd1}) begin
      bad++;
      $display("FAIL zero_masks_step1 got=%h/%0d want=ff/1", x_out, step_cnt);
    end
    wait_done(ok);
    e = exp_q.pop_front();
    got = {status, period, step_cnt, x_out};
    total++;
    if (!ok || got !== e) begin
      bad++;
      $display("FAIL zero_masks_fixed done=%b got=%h want=%h", done, got, e);
    end
  endtask

  initial begin
    test_reset();
    load_rules();
    test_fixed_point();
    test_cycle();
    test_timeout();
    test_hist1();
    test_ignored();
    test_mid_reset();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_left got=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gene_net_sim.md
Name: gene_net_sim

Overview:
- Parametrised, programmable synchronous Boolean gene-network simulator.
- N genes; each gene's next value comes from run-time-loaded activator/repressor masks instead of fixed equations.
- Runs from a seed state, one network step per clock, until it finds a fixed point, a cycle (attractor period up to HIST), or a step limit.
- Drives the trajectory and attractor results toward the analysis/readout logic.

Parameters:
- N, 8, number of genes (state width); N >= 2.
- HIST, 8, attractor-detection window; cycles of period 1..HIST are detected; HIST >= 1.
- CW, 16, width of step counter and max_steps.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- cfg_we  in  1  rule write strobe.
- cfg_gene  in  $clog2(N)  target gene index.
- cfg_sel  in  2  0 = ANY mask, 1 = ALL mask, 2 = REP mask, 3 = ignored.
- cfg_mask  in  N  mask value to write.
- start  in  1  one-cycle pulse that launches a run.
- seed  in  N  initial state.
- max_steps  in  CW  step limit; 0 = unlimited.
- busy  out  1  high while running.
- done  out  1  high in DONE until the next start.
- status  out  2  0 = none, 1 = fixed point, 2 = cycle, 3 = timeout.
- period  out  $clog2(HIST+1)  detected attractor period (0 if none).
- step_cnt  out  CW  steps executed.
- x_out  out  N  current network state.

Behaviour:
- Rule per gene i, evaluated on current state s:
  nxt[i] = (ANY[i]==0 | |(s & ANY[i])) & ((s & ALL[i]) == ALL[i]) & ~|(s & REP[i]).
  All masks zero gives constant 1.
- Reset (rst_n low at clk edge):
  - All masks set to 0; history cleared.
  - FSM to IDLE.
  - busy = 0, done = 0, status = 0, period = 0, step_cnt = 0, x_out = 0.
  - Reset aborts any run in progress.
- Config writes:
  - Applied on the clk edge in IDLE or DONE only; ignored in RUN.
  - Ignored if cfg_gene >= N or cfg_sel == 3.
- FSM states: IDLE, RUN, DONE.
  - IDLE/DONE + start:
    - x_out <= seed; step_cnt <= 0; history valid bits cleared.
    - done <= 0; status <= 0; period <= 0; busy <= 1; go to RUN.
  - start is ignored in RUN.
- RUN, every clock:
  - Compute nxt from x_out.
  - x_out <= nxt; step_cnt <= step_cnt+1.
  - Push the old x_out into the history shift register H[0..HIST-2] (H[0] newest).
- Attractor compare, done on nxt in the same cycle:
  - Compare nxt == x_out, which gives period 1.
  - Compare nxt == valid H[k], which gives period k+2 (k < HIST-1).
  - The smallest matching period wins.
- On a match:
  - Go to DONE; busy <= 0; done <= 1; period <= p.
  - status <= 1 if p == 1, else 2.
  - x_out and step_cnt still take the updated values.
- Timeout:
  - No match and max_steps != 0 and step_cnt+1 == max_steps: go to DONE with status 3, period 0.
  - A match takes priority over timeout in the same cycle.
- max_steps == 0 runs until a match. step_cnt saturates at all-ones (no wrap) and the run continues.
- Latency: result visible the edge after the detecting step. A period-p cycle entered at step t is reported at step t+p.
- All outputs are registered.

Test Plan:
- Rules for the 8-gene test network, written as ANY/ALL/REP per gene:
  - g0: 0 / 40 / 84
  - g1: 30 / 0 / 80
  - g2: 0 / 80 / 0
  - g3: 0 / 02 / 40
  - g4: 0A / 0 / 0
  - g5: 0 / 04 / 80
  - g6: 0 / 02 / 80
  - g7: 48 / 0 / 03
- Scenarios:
  - Test rules loaded, seed 0x00, max_steps 0, start -> after 1 step: done, status 1, period 1, step_cnt 1, x_out 0x00.
  - Test rules loaded, seed 0x02, max_steps 0 -> trajectory 0x58, 0x93, 0x1C, 0xB2, 0x1C; done at step_cnt 5, status 2, period 2, x_out 0x1C.
  - Same as previous, max_steps 3 -> done, status 3, period 0, step_cnt 3, x_out 0x1C.
  - HIST=1 build, seed 0x02, max_steps 20 -> no cycle detected; status 3, step_cnt 20, x_out 0xB2.
  - Reset mid-run, then seed 0x00 with masks left zero -> x_out 0xFF at step 1; fixed point at step 2, status 1, period 1.
  - cfg_we pulsed during RUN and start re-pulsed during RUN -> both ignored; the run result is identical to the unperturbed run.
